// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA data-memory arbiter: FSM states, owner ids,
// and the default memory depth.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int unsigned MEM_WORDS_DEFAULT = 3072;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-port round-robin arbiter: a tie goes to the port not granted most recently,
// a lone requester always wins, and the pointer moves on every accepted grant.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt_onehot
);

    // Set when DMA should win the next tie.
    logic r_prio_dma;

    always_comb begin
        gnt_onehot = '0;
        if (req == 2'b11) begin
            gnt_onehot = r_prio_dma ? 2'b10 : 2'b01;
        end else begin
            gnt_onehot = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_dma <= 1'b0;
        end else if (update) begin
            r_prio_dma <= gnt_onehot[OWN_CPU];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and DMA word accesses onto a single-port data memory: grant in
// IDLE, one ACCESS cycle on the memory bus, registered done/err/rdata one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:2] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_gnt,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [13:2] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic        MemWrite,
    output logic [13:2] mem_addr,
    output logic [31:0] mem_dataIn,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_dataOut
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_grant;
    logic        w_access;
    logic        w_in_range;

    logic        r_we;
    logic [13:2] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        r_owner;

    logic        r_cpu_done;
    logic        r_cpu_err;
    logic [31:0] r_cpu_rdata;
    logic        r_dma_done;
    logic        r_dma_err;
    logic [31:0] r_dma_rdata;

    assign w_req = {dma_req, cpu_req};

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .req        (w_req),
        .update     (w_grant),
        .gnt_onehot (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset && (|w_req)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign cpu_gnt = w_grant & w_gnt[OWN_CPU];
    assign dma_gnt = w_grant & w_gnt[OWN_DMA];

    // Reset gates the bus combinationally so an aborted access never strobes the memory.
    assign w_access   = (r_state == ACCESS) && !reset;
    assign w_in_range = 32'(r_addr) < MEM_WORDS;

    assign MemWrite   = w_access & r_we & w_in_range;
    assign mem_addr   = w_access ? r_addr  : '0;
    assign mem_dataIn = w_access ? r_wdata : '0;
    assign mem_pc     = w_access ? r_pc    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_pc    <= '0;
            r_owner <= OWN_CPU;
        end else if (w_grant) begin
            r_owner <= w_gnt[OWN_DMA];
            r_we    <= w_gnt[OWN_DMA] ? dma_we    : cpu_we;
            r_addr  <= w_gnt[OWN_DMA] ? dma_addr  : cpu_addr;
            r_wdata <= w_gnt[OWN_DMA] ? dma_wdata : cpu_wdata;
            r_pc    <= w_gnt[OWN_DMA] ? '0        : cpu_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_done  <= 1'b0;
            r_dma_err   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_cpu_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_done  <= 1'b0;
            r_dma_err   <= 1'b0;
            r_dma_rdata <= '0;
            if (r_state == ACCESS) begin
                if (r_owner == OWN_CPU) begin
                    r_cpu_done  <= 1'b1;
                    r_cpu_err   <= !w_in_range;
                    r_cpu_rdata <= w_in_range ? mem_dataOut : '0;
                end else begin
                    r_dma_done  <= 1'b1;
                    r_dma_err   <= !w_in_range;
                    r_dma_rdata <= w_in_range ? mem_dataOut : '0;
                end
            end
        end
    end

    assign cpu_done  = r_cpu_done;
    assign cpu_err   = r_cpu_err;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_done  = r_dma_done;
    assign dma_err   = r_dma_err;
    assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-level reference model queues expected
// grants, bus cycles and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;

    localparam int unsigned MEMW = 3072;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [13:2] cpu_addr, dma_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_pc, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_dataIn, mem_pc, mem_dataOut;
    logic        cpu_gnt, cpu_done, cpu_err, dma_gnt, dma_done, dma_err, MemWrite;

    mem_arbiter #(.MEM_WORDS(MEMW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .MemWrite(MemWrite), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
        .mem_pc(mem_pc), .mem_dataOut(mem_dataOut)
    );

    // Environment memory: unwritten words read back a fixed hash of their address.
    function automatic logic [31:0] seed(input int unsigned a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    logic [31:0] env_mem [0:4095];
    bit          env_vld [0:4095];
    always @(posedge clk) begin
        if (MemWrite) begin
            env_mem[mem_addr] <= mem_dataIn;
            env_vld[mem_addr] <= 1'b1;
        end
    end
    assign mem_dataOut = (32'(mem_addr) >= MEMW) ? 32'hBAD0_BAD0 :
                         env_vld[mem_addr] ? env_mem[mem_addr] : seed(32'(mem_addr));

    typedef struct { int cyc; int port; } gexp_t;
    typedef struct { int cyc; logic mw; logic [13:2] addr; logic [31:0] wd; logic [31:0] pc; } aexp_t;
    typedef struct { int cyc; int port; logic [31:0] rd; logic err; } dexp_t;
    typedef struct { int cyc; int port; logic we; logic [13:2] addr; logic [31:0] wd; logic [31:0] pc; } pend_t;

    gexp_t gq[$];
    aexp_t aq[$];
    dexp_t dq[$];

    logic [31:0] ref_mem [0:4095];
    int    last_port;
    int    free_at;
    bit    pend_v;
    pend_t pend;

    int cyc;
    int n_cmp;
    int n_bad;

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Reference model, evaluated once per cycle after the inputs for that cycle are applied.
    task automatic eval(output int g);
        aexp_t a;
        dexp_t d;
        gexp_t ge;
        logic  inr;
        g = -1;
        if (pend_v && pend.cyc == cyc) begin
            pend_v = 1'b0;
            if (!reset) begin
                inr    = 32'(pend.addr) < MEMW;
                a.cyc  = cyc;
                a.mw   = pend.we && inr;
                a.addr = pend.addr;
                a.wd   = pend.wd;
                a.pc   = pend.pc;
                aq.push_back(a);
                d.cyc  = cyc + 1;
                d.port = pend.port;
                d.rd   = inr ? ref_mem[pend.addr] : 32'h0;
                d.err  = !inr;
                dq.push_back(d);
                if (pend.we && inr) ref_mem[pend.addr] = pend.wd;
            end
        end
        if (reset) begin
            last_port = 1;
            free_at   = cyc + 1;
        end else if (cyc >= free_at && (cpu_req || dma_req)) begin
            if (cpu_req && dma_req) g = 1 - last_port;
            else                    g = cpu_req ? 0 : 1;
            last_port = g;
            free_at   = cyc + 2;
            ge.cyc    = cyc;
            ge.port   = g;
            gq.push_back(ge);
            pend_v    = 1'b1;
            pend.cyc  = cyc + 1;
            pend.port = g;
            pend.we   = (g == 0) ? cpu_we    : dma_we;
            pend.addr = (g == 0) ? cpu_addr  : dma_addr;
            pend.wd   = (g == 0) ? cpu_wdata : dma_wdata;
            pend.pc   = (g == 0) ? cpu_pc    : 32'h0;
        end
    endtask

    task automatic go(input logic creq, input logic cwe, input logic [13:2] caddr,
                      input logic [31:0] cwd, input logic [31:0] cpc,
                      input logic dreq, input logic dwe, input logic [13:2] daddr,
                      input logic [31:0] dwd, input logic rst, output int g);
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd; cpu_pc = cpc;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        eval(g);
    endtask

    task automatic idle(input logic rst);
        int g;
        go(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, rst, g);
    endtask

    function automatic logic [13:2] rand_addr();
        case ($urandom_range(9, 0))
            0:       return 12'(3072 + $urandom_range(1023, 0));
            1:       return 12'd3071;
            default: return 12'($urandom_range(63, 0));
        endcase
    endfunction

    function automatic logic [1:0] onehot(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    gexp_t mg;
    aexp_t ma;
    dexp_t md;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (cpu_gnt || dma_gnt) begin
                if (gq.size() == 0) begin
                    chk("gnt_spurious", 96'({dma_gnt, cpu_gnt}), 96'(0));
                end else begin
                    mg = gq.pop_front();
                    chk("gnt_cycle", 96'(cyc), 96'(mg.cyc));
                    chk("gnt_port", 96'({dma_gnt, cpu_gnt}), 96'(onehot(mg.port)));
                end
            end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                mg = gq.pop_front();
                chk("gnt_missing", 96'({dma_gnt, cpu_gnt}), 96'(onehot(mg.port)));
            end

            if (aq.size() != 0 && aq[0].cyc == cyc) begin
                ma = aq.pop_front();
                chk("mem_we", 96'(MemWrite), 96'(ma.mw));
                chk("mem_addr", 96'(mem_addr), 96'(ma.addr));
                chk("mem_dataIn", 96'(mem_dataIn), 96'(ma.wd));
                chk("mem_pc", 96'(mem_pc), 96'(ma.pc));
            end else begin
                chk("bus_idle", 96'({MemWrite, mem_addr, mem_dataIn, mem_pc}), 96'(0));
            end

            if (cpu_done || dma_done) begin
                if (dq.size() == 0) begin
                    chk("done_spurious", 96'({dma_done, cpu_done}), 96'(0));
                end else begin
                    md = dq.pop_front();
                    chk("done_cycle", 96'(cyc), 96'(md.cyc));
                    chk("done_port", 96'({dma_done, cpu_done}), 96'(onehot(md.port)));
                    if (md.port == 0) begin
                        chk("cpu_resp", 96'({cpu_err, cpu_rdata}), 96'({md.err, md.rd}));
                        chk("dma_quiet", 96'({dma_err, dma_rdata}), 96'(0));
                    end else begin
                        chk("dma_resp", 96'({dma_err, dma_rdata}), 96'({md.err, md.rd}));
                        chk("cpu_quiet", 96'({cpu_err, cpu_rdata}), 96'(0));
                    end
                end
            end else begin
                if (dq.size() != 0 && dq[0].cyc <= cyc) begin
                    md = dq.pop_front();
                    chk("done_missing", 96'({dma_done, cpu_done}), 96'(onehot(md.port)));
                end
                chk("resp_idle", 96'({cpu_err, dma_err, cpu_rdata, dma_rdata}), 96'(0));
            end
        end
    end

    initial begin
        int  g;
        bit  ch, dh, rst;
        logic c_we, d_we;
        logic [13:2] c_addr, d_addr;
        logic [31:0] c_wd, c_pc, d_wd;

        n_cmp = 0; n_bad = 0; cyc = 0;
        last_port = 1; free_at = 0; pend_v = 1'b0;
        for (int unsigned i = 0; i < 4096; i++) ref_mem[i] = seed(i);
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_pc = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

        repeat (3) idle(1'b1);

        // Single CPU write, then DMA read-back of the same word.
        go(1'b1, 1'b1, 12'h005, 32'hDEAD_BEEF, 32'h0000_3000, 1'b0, 1'b0, '0, '0, 1'b0, g);
        repeat (2) idle(1'b0);
        go(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h005, '0, 1'b0, g);
        repeat (2) idle(1'b0);

        // Both ports requesting continuously straight out of reset.
        repeat (2) idle(1'b1);
        for (int unsigned i = 0; i < 8; i++)
            go(1'b1, 1'b0, 12'(i), '0, 32'(i), 1'b1, 1'b0, 12'(i + 20), '0, 1'b0, g);
        repeat (2) idle(1'b0);

        // Out-of-range write at the first illegal address.
        go(1'b1, 1'b1, 12'hC00, 32'h1111_2222, 32'h40, 1'b0, 1'b0, '0, '0, 1'b0, g);
        repeat (2) idle(1'b0);

        // Write aborted by reset in its ACCESS cycle; read-back must see the old value.
        go(1'b1, 1'b1, 12'h010, 32'h1234_5678, 32'h50, 1'b0, 1'b0, '0, '0, 1'b0, g);
        repeat (2) idle(1'b0);
        go(1'b1, 1'b1, 12'h010, 32'hFFFF_0000, 32'h54, 1'b0, 1'b0, '0, '0, 1'b0, g);
        idle(1'b1);
        idle(1'b0);
        go(1'b1, 1'b0, 12'h010, '0, 32'h58, 1'b0, 1'b0, '0, '0, 1'b0, g);
        repeat (2) idle(1'b0);

        // One port granted while the other's request is withdrawn the next cycle.
        go(1'b1, 1'b1, 12'h007, 32'hA5A5_0007, 32'h60, 1'b1, 1'b0, 12'h008, '0, 1'b0, g);
        idle(1'b0);
        repeat (3) idle(1'b0);

        ch = 1'b0; dh = 1'b0;
        c_we = 1'b0; d_we = 1'b0; c_addr = '0; d_addr = '0; c_wd = '0; c_pc = '0; d_wd = '0;
        for (int unsigned n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99, 0) == 0);
            if (ch && $urandom_range(15, 0) == 0) ch = 1'b0;
            else if (!ch && $urandom_range(1, 0) == 1) begin
                ch = 1'b1; c_we = 1'($urandom_range(1, 0)); c_addr = rand_addr();
                c_wd = $urandom; c_pc = $urandom;
            end
            if (dh && $urandom_range(15, 0) == 0) dh = 1'b0;
            else if (!dh && $urandom_range(1, 0) == 1) begin
                dh = 1'b1; d_we = 1'($urandom_range(1, 0)); d_addr = rand_addr();
                d_wd = $urandom;
            end
            go(ch, c_we, c_addr, c_wd, c_pc, dh, d_we, d_addr, d_wd, rst, g);
            if (g == 0) ch = 1'b0;
            if (g == 1) dh = 1'b0;
        end

        repeat (4) idle(1'b0);
        @(posedge clk);
        #1;
        chk("gnt_queue_drained", 96'(gq.size()), 96'(0));
        chk("bus_queue_drained", 96'(aq.size()), 96'(0));
        chk("done_queue_drained", 96'(dq.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 3072, SHALL give the number of words in the data memory; word addresses at or above it are out of range.
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req, cpu_we  input  1 each  CPU access request and write select; SHALL be held with cpu_addr and cpu_wdata until cpu_gnt.
REQ-005 cpu_addr  input  [13:2]  CPU word address.
REQ-006 cpu_wdata, cpu_pc  input  32 each  CPU store data and instruction PC.
REQ-007 cpu_gnt, cpu_done, cpu_err  output  1 each  CPU accepted pulse, completion pulse, and out-of-range flag.
REQ-008 cpu_rdata  output  32  CPU read data, valid while cpu_done is high.
REQ-009 dma_req, dma_we, dma_addr[13:2], dma_wdata[32]  input  DMA request, with the same hold rule as the CPU port.
REQ-010 dma_gnt, dma_done, dma_err, dma_rdata[32]  output  DMA response, with the same semantics as the CPU port.
REQ-011 MemWrite  output  1  write strobe to the data memory.
REQ-012 mem_addr  output  [13:2]  memory word address.
REQ-013 mem_dataIn, mem_pc  output  32 each  memory write data and PC for the memory's write log.
REQ-014 mem_dataOut  input  32  combinational read data from the memory.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-016 In IDLE with any request asserted, the block SHALL do all of the following in the same cycle:
  - pulse the winner's gnt combinationally;
  - latch the winner's we, addr, wdata and pc (pc is 0 for DMA) and the owner id;
  - enter ACCESS.
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE and drive no gnt.
REQ-018 Arbitration SHALL be round-robin between the two ports:
  - the port not granted most recently wins a simultaneous request;
  - a lone requester always wins;
  - the priority pointer SHALL update on every grant.
REQ-019 ACCESS SHALL last exactly one cycle and SHALL drive mem_addr, mem_dataIn and mem_pc from the latched request.
REQ-020 In ACCESS, MemWrite SHALL be 1 only for an in-range write (addr < MEM_WORDS); it SHALL be 0 in every other state and case.
REQ-021 Outside ACCESS, mem_addr, mem_dataIn and mem_pc SHALL be 0.
REQ-022 At the end of ACCESS the block SHALL:
  - register mem_dataOut into the owner's rdata, or 0 for an out-of-range access;
  - register done=1 for the owner, err=1 if out of range;
  - return to IDLE.
REQ-023 done, err and rdata SHALL be valid for exactly one cycle.
REQ-024 The non-owner's done, err and rdata SHALL be 0.
REQ-025 Latency SHALL be: request accepted in IDLE at cycle t -> memory write/read at cycle t+1 -> done at cycle t+2.
REQ-026 A new grant MAY occur in the same cycle as done, giving a peak throughput of one access per 2 cycles.
REQ-027 A write SHALL be committed by the memory at the rising edge that ends ACCESS.
REQ-028 A read SHALL return the memory contents before any write in that same edge.
REQ-029 A request that drops before gnt SHALL be dropped silently, with no access.
REQ-030 A request held after gnt SHALL be treated as a new request.
REQ-031 No request SHALL be lost while both ports are asserted: each port is served within 2 accesses.

Reset
REQ-032 On reset the block SHALL:
  - set state=IDLE;
  - set the priority pointer to favour the CPU;
  - clear all latched fields.
REQ-033 On reset all gnt, done, err, MemWrite, rdata and mem_* outputs SHALL be 0.
REQ-034 Reset asserted during ACCESS SHALL abort the access: no MemWrite in any cycle with reset high, and no done is produced.
REQ-035 The block SHALL NOT clear memory contents; the memory has its own reset.

Structure
REQ-036 A shared package SHALL hold:
  - the state encoding (IDLE, ACCESS);
  - the owner ids (OWN_CPU=0, OWN_DMA=1);
  - the MEM_WORDS default.
REQ-037 The round-robin decision SHALL be a sub-module rr_arb2 with these ports:
  - req[1:0], update and reset as inputs;
  - gnt_onehot[1:0] as output.
REQ-038 The FSM, request latch and response registers SHALL reside in mem_arbiter.

Verification
REQ-039 Single CPU write, addr=0x005, wdata=0xDEADBEEF, pc=0x3000 -> cpu_gnt at t; MemWrite=1 with mem_addr=0x005 at t+1; cpu_done=1 and cpu_err=0 at t+2.
REQ-040 DMA read of addr 0x005 after REQ-039 -> dma_done at t+2 with dma_rdata=0xDEADBEEF; cpu_done stays 0.
REQ-041 CPU and DMA both requesting continuously from reset -> grant order CPU, DMA, CPU, DMA; a gnt every 2 cycles.
REQ-042 CPU write to addr 0xC00 (=3072) -> MemWrite stays 0; cpu_done=1, cpu_err=1, cpu_rdata=0.
REQ-043 Reset raised during the ACCESS cycle of a write to 0x010 -> no MemWrite and no done; a later read of 0x010 returns its prior value.
REQ-044 Request dropped in a cycle where the other port is granted -> the dropped request gets no gnt and no done, and no access occurs for it.
